// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - fetch PC generator port bundle (redirects, BTB/predictor inputs, PC and RAS outputs)
interface fetch_pc_gen_if #(
    parameter int PC_W        = 32,
    parameter int FETCH_WIDTH = 4,
    parameter int RAS_DEPTH   = 16
);
    localparam int TOS_W  = $clog2(RAS_DEPTH);
    localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    logic                        stall_i;
    logic                        recover_valid_i;
    logic [PC_W-1:0]             recover_pc_i;
    logic [TOS_W-1:0]            recover_tos_i;
    logic                        exception_valid_i;
    logic [PC_W-1:0]             exception_pc_i;
    logic                        redirect_ex_valid_i;
    logic [PC_W-1:0]             redirect_ex_pc_i;
    logic                        redirect_id_valid_i;
    logic [PC_W-1:0]             redirect_id_pc_i;
    logic [FETCH_WIDTH-1:0]      btb_hit_i;
    logic [2*FETCH_WIDTH-1:0]    btb_type_i;
    logic [FETCH_WIDTH*PC_W-1:0] btb_target_i;
    logic [FETCH_WIDTH-1:0]      pred_i;
    logic [PC_W-1:0]             pc_o;
    logic [PC_W-1:0]             next_pc_o;
    logic                        taken_valid_o;
    logic [SLOT_W-1:0]           taken_slot_o;
    logic [PC_W-1:0]             ras_top_o;
    logic [TOS_W-1:0]            ras_tos_o;
    logic                        ras_empty_o;
    logic                        ras_full_o;

    modport master (
        output stall_i, recover_valid_i, recover_pc_i, recover_tos_i,
               exception_valid_i, exception_pc_i, redirect_ex_valid_i, redirect_ex_pc_i,
               redirect_id_valid_i, redirect_id_pc_i, btb_hit_i, btb_type_i, btb_target_i, pred_i,
        input  pc_o, next_pc_o, taken_valid_o, taken_slot_o, ras_top_o, ras_tos_o,
               ras_empty_o, ras_full_o
    );

    modport slave (
        input  stall_i, recover_valid_i, recover_pc_i, recover_tos_i,
               exception_valid_i, exception_pc_i, redirect_ex_valid_i, redirect_ex_pc_i,
               redirect_id_valid_i, redirect_id_pc_i, btb_hit_i, btb_type_i, btb_target_i, pred_i,
        output pc_o, next_pc_o, taken_valid_o, taken_slot_o, ras_top_o, ras_tos_o,
               ras_empty_o, ras_full_o
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch stage 1 next-PC generator with circular return address stack
// Optional: FETCH_PC_GEN_RAS_REPAIR_EN restores the RAS TOS from recover_tos_i on recovery.
module fetch_pc_gen #(
    parameter int              PC_W        = 32,
    parameter int              FETCH_WIDTH = 4,
    parameter int              INST_BYTES  = 8,
    parameter int              RAS_DEPTH   = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_pc_gen_if.slave      bus
);
    localparam int TOS_W  = $clog2(RAS_DEPTH);
    localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int CNT_W  = TOS_W + 1;
    localparam logic [PC_W-1:0]  BUNDLE_BYTES = PC_W'(FETCH_WIDTH * INST_BYTES);
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(RAS_DEPTH);
    localparam logic [1:0] T_RET  = 2'b00;
    localparam logic [1:0] T_CALL = 2'b01;
    localparam logic [1:0] T_COND = 2'b11;

    logic [PC_W-1:0]        pc_q, pc_d;
    logic [TOS_W-1:0]       tos_q, tos_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PC_W-1:0]        ras_q [RAS_DEPTH];

    logic [FETCH_WIDTH-1:0] taken;
    logic                   found;
    logic [SLOT_W-1:0]      slot;
    logic [1:0]             slot_type;
    logic [PC_W-1:0]        slot_target;
    logic [PC_W-1:0]        slot_ret;
    logic [PC_W-1:0]        pred_pc;
    logic                   take_pred;
    logic                   ras_we;

    always_comb begin
        taken = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            taken[i] = bus.btb_hit_i[i] & ((bus.btb_type_i[2*i +: 2] != T_COND) | bus.pred_i[i]);
        end
    end

    // Descending scan so the lowest taken slot is the last (winning) assignment.
    always_comb begin
        found       = 1'b0;
        slot        = '0;
        slot_type   = '0;
        slot_target = '0;
        slot_ret    = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (taken[i]) begin
                found       = 1'b1;
                slot        = SLOT_W'(i);
                slot_type   = bus.btb_type_i[2*i +: 2];
                slot_target = bus.btb_target_i[i*PC_W +: PC_W];
                slot_ret    = pc_q + PC_W'((i + 1) * INST_BYTES);
            end
        end
    end

    always_comb begin
        if (!found)                  pred_pc = pc_q + BUNDLE_BYTES;
        else if (slot_type == T_RET) pred_pc = ras_q[tos_q];
        else                         pred_pc = slot_target;
    end

    always_comb begin
        take_pred = 1'b0;
        if (bus.recover_valid_i)                          pc_d = bus.recover_pc_i;
        else if (bus.exception_valid_i)                   pc_d = bus.exception_pc_i;
        else if (bus.redirect_ex_valid_i)                 pc_d = bus.redirect_ex_pc_i;
        else if (bus.redirect_id_valid_i && !bus.stall_i) pc_d = bus.redirect_id_pc_i;
        else if (bus.stall_i)                             pc_d = pc_q;
        else begin
            pc_d      = pred_pc;
            take_pred = 1'b1;
        end
    end

    // RAS only moves when fetch follows its own prediction; count saturates, TOS always wraps.
    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        ras_we  = 1'b0;
        if (take_pred && found) begin
            if (slot_type == T_CALL) begin
                tos_d   = tos_q + TOS_W'(1);
                ras_we  = 1'b1;
                count_d = (count_q == DEPTH_C) ? count_q : count_q + CNT_W'(1);
            end else if (slot_type == T_RET) begin
                tos_d   = tos_q - TOS_W'(1);
                count_d = (count_q == '0) ? count_q : count_q - CNT_W'(1);
            end
        end
`ifdef FETCH_PC_GEN_RAS_REPAIR_EN
        if (bus.recover_valid_i) begin
            tos_d   = bus.recover_tos_i;
            count_d = (count_q > DEPTH_C) ? DEPTH_C : count_q;
        end
`endif
    end

`ifndef FETCH_PC_GEN_RAS_REPAIR_EN
    logic unused_recover_tos;
    assign unused_recover_tos = ^bus.recover_tos_i;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            tos_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            tos_q   <= tos_d;
            count_q <= count_d;
            if (ras_we) ras_q[tos_d] <= slot_ret;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.next_pc_o     = pc_d;
    assign bus.taken_valid_o = found;
    assign bus.taken_slot_o  = slot;
    assign bus.ras_top_o     = ras_q[tos_q];
    assign bus.ras_tos_o     = tos_q;
    assign bus.ras_empty_o   = (count_q == '0);
    assign bus.ras_full_o    = (count_q == DEPTH_C);
endmodule
